// File: rtl/sw_window_fsm.sv
// -----------------------------------------------------------------------------
// sw_window_fsm
//
// Moore FSM that waits for a start pulse on `s`, then samples `w` in
// consecutive, non-overlapping 3-cycle windows. `z` is high for exactly one
// cycle after any window in which `w` was 1 in exactly two of the three cycles.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset (0 = asserted)
//   s          in   1      start request, only looked at while idle (state A)
//   w          in   1      data bit counted in each 3-cycle window
//   z          out  1      registered; high the cycle after a two-ones window
//   match_cnt  out  CNT_W  (MATCH_CNT_EN only) saturating count of matches
//
// Configuration macro:
//   MATCH_CNT_EN  adds the match_cnt output and its saturating counter.
//
// State naming: S<xy> = x window cycles consumed, y ones seen so far.
// B and C both mean "next sample opens a new window"; C additionally marks
// that the window just finished matched, which is what drives z.
// -----------------------------------------------------------------------------
module sw_window_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             w,
  output logic             z
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  // Encoding is fixed: all eight 3-bit codes are legal states.
  typedef enum logic [2:0] {
    ST_A   = 3'd0,
    ST_B   = 3'd1,
    ST_C   = 3'd2,
    ST_S10 = 3'd3,
    ST_S11 = 3'd4,
    ST_S20 = 3'd5,
    ST_S21 = 3'd6,
    ST_S22 = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  // Reject a zero-width counter configuration at elaboration time.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("sw_window_fsm: CNT_W must be at least 1");
  end

  // Next-state decode. Once A is left, s is never consulted again.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_nxt and no
    // latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_A:         state_nxt = s ? ST_B : ST_A;
      ST_B, ST_C:   state_nxt = w ? ST_S11 : ST_S10;
      ST_S10:       state_nxt = w ? ST_S21 : ST_S20;
      ST_S11:       state_nxt = w ? ST_S22 : ST_S21;
      ST_S20:       state_nxt = ST_B;                 // two ones now unreachable
      ST_S21:       state_nxt = w ? ST_C   : ST_B;
      ST_S22:       state_nxt = w ? ST_B   : ST_C;    // w=1 would make three ones
      default:      state_nxt = ST_A;
    endcase
  end

  // z is registered from the next-state decode so that it equals
  // (state == C) without any combinational path from s or w to the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state <= ST_A;
      z     <= 1'b0;
`ifdef MATCH_CNT_EN
      match_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      z     <= (state_nxt == ST_C);
`ifdef MATCH_CNT_EN
      // Count on the same edge that raises z; hold at all-ones instead of wrapping.
      if ((state_nxt == ST_C) && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_sw_window_fsm.sv
// -----------------------------------------------------------------------------
// tb_sw_window_fsm
//
// Self-checking bench for sw_window_fsm. A behavioural window model (start
// flag, position within window, ones count) predicts z for every clock edge;
// predictions are queued when stimulus is driven and popped when z is sampled
// 1 time unit after the edge. Directed tasks cover reset, matching and
// non-matching windows, back-to-back windows, s after start and async reset.
// With MATCH_CNT_EN the DUT is built with CNT_W=2 to reach saturation.
// -----------------------------------------------------------------------------
module tb_sw_window_fsm;

`ifdef MATCH_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  logic s;
  logic w;
  logic z;
`ifdef MATCH_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard and model state.
  bit exp_q[$];
  bit m_started;
  int m_pos;
  int m_ones;
  int m_matches;

  sw_window_fsm #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .w     (w),
    .z     (z)
`ifdef MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic model_clear();
    m_started = 1'b0;
    m_pos     = 0;
    m_ones    = 0;
    m_matches = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of s/w, predict z after the edge, then sample and compare.
  task automatic step(input logic s_in, input logic w_in, input string name);
    bit expz;
    bit got_exp;
    s    = s_in;
    w    = w_in;
    expz = 1'b0;
    if (!m_started) begin
      if (s_in) begin
        m_started = 1'b1;
        m_pos     = 0;
        m_ones    = 0;
      end
    end else begin
      m_ones += int'(w_in);
      m_pos++;
      if (m_pos == 3) begin
        expz = (m_ones == 2);
        if (expz) m_matches++;
        m_pos  = 0;
        m_ones = 0;
      end
    end
    exp_q.push_back(expz);
    @(posedge clk);
    #1;
    got_exp = exp_q.pop_front();
    checks++;
    if (z !== got_exp) begin
      failures++;
      $display("FAIL %s: z=%b expected %b at %0t", name, z, got_exp, $time);
    end
  endtask

  // Assert reset between edges, check z drops immediately, release mid-cycle.
  task automatic do_reset(input string name);
    reset = 1'b0;
    #2;
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL %s_z_in_reset: z=%b expected 0", name, z);
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic run_window(input logic [2:0] bits, input string name);
    for (int i = 2; i >= 0; i--) step(1'b0, bits[i], name);
  endtask

`ifdef MATCH_CNT_EN
  task automatic check_cnt(input string name);
    int exp_cnt;
    exp_cnt = (m_matches > (2**CW - 1)) ? (2**CW - 1) : m_matches;
    checks++;
    if (match_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL %s: match_cnt=%0d expected %0d", name, match_cnt, exp_cnt);
    end
  endtask
`endif

  task automatic test_reset();
    s     = 1'b0;
    w     = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: z=%b expected 0", z);
    end
    reset = 1'b1;
    // Idle with s=0: any w pattern must leave z low.
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), "idle");
  endtask

  task automatic test_two_ones();
    logic [2:0] pats[3] = '{3'b110, 3'b101, 3'b011};
    foreach (pats[p]) begin
      do_reset("two_ones");
      step(1'b1, 1'b0, "two_ones_start");
      run_window(pats[p], "two_ones");
      step(1'b0, 1'b0, "two_ones_after");   // z must be a single-cycle pulse
      step(1'b0, 1'b0, "two_ones_after");
    end
  endtask

  task automatic test_non_match();
    do_reset("non_match");
    step(1'b1, 1'b0, "non_match_start");
    run_window(3'b111, "three_ones");
    run_window(3'b000, "zero_ones");
    run_window(3'b100, "one_one");
    step(1'b0, 1'b0, "non_match_after");
  endtask

  task automatic test_back_to_back();
    do_reset("b2b");
    step(1'b1, 1'b0, "b2b_start");
    run_window(3'b011, "b2b_w1");
    run_window(3'b101, "b2b_w2");
    step(1'b0, 1'b1, "b2b_after");
    run_window(3'b110, "b2b_w4");   // window opened by previous step: 1,1,1,0 -> continues
    step(1'b0, 1'b0, "b2b_tail");
  endtask

  task automatic test_s_ignored();
    logic [11:0] pat = 12'b011_110_101_111;
    // Random s during windows.
    do_reset("s_rand");
    step(1'b1, 1'b0, "s_rand_start");
    for (int i = 11; i >= 0; i--) step(1'($urandom_range(0, 1)), pat[i], "s_rand");
    // s held high throughout.
    do_reset("s_hold");
    step(1'b1, 1'b0, "s_hold_start");
    for (int i = 11; i >= 0; i--) step(1'b1, pat[i], "s_hold");
  endtask

  task automatic test_async_reset();
    // Reset while in S21: afterwards a w=1 that would have matched must not.
    do_reset("async");
    step(1'b1, 1'b0, "async_start");
    step(1'b0, 1'b1, "async_s11");
    step(1'b0, 1'b0, "async_s21");
    do_reset("async_s21");
    step(1'b0, 1'b1, "async_after_s21");
    for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom_range(0, 1)), "async_idle");
    // Reset while z is high (state C): z must fall before the next edge.
    step(1'b1, 1'b0, "async_restart");
    run_window(3'b110, "async_to_c");
    do_reset("async_c");
`ifdef MATCH_CNT_EN
    check_cnt("cnt_after_reset");
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom_range(0, 1)), "async_post");
  endtask

`ifdef MATCH_CNT_EN
  task automatic test_match_cnt();
    do_reset("cnt");
    check_cnt("cnt_zero");
    step(1'b1, 1'b0, "cnt_start");
    run_window(3'b110, "cnt_w1");
    check_cnt("cnt_one");
    run_window(3'b111, "cnt_nomatch");
    check_cnt("cnt_one_hold");
    run_window(3'b101, "cnt_w2");
    run_window(3'b011, "cnt_w3");
    check_cnt("cnt_three");
    run_window(3'b110, "cnt_w4");
    run_window(3'b110, "cnt_w5");
    check_cnt("cnt_saturated");
  endtask
`endif

  initial begin
    test_reset();
    test_two_ones();
    test_non_match();
    test_back_to_back();
    test_s_ignored();
    test_async_reset();
`ifdef MATCH_CNT_EN
    test_match_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
